// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state encoding and flag indices for the ALU share controller
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bit positions inside the {Z,V,N} flag register
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin grant; ALU_SHARE_FIXED_PRIO_EN selects fixed port-0 priority
module arb_rr2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] grant_o
);

`ifdef ALU_SHARE_FIXED_PRIO_EN

    // Port 0 wins every contention; no pointer state exists in this build
    always_comb begin
        grant_o = 2'b00;
        if (req_i[0]) begin
            grant_o = 2'b01;
        end else if (req_i[1]) begin
            grant_o = 2'b10;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, adv_i};

`else

    // ptr_q names the port favoured on the next contention (0 after reset)
    logic ptr_q;
    logic ptr_d;

    // Sole requester wins outright; the pointer only breaks ties
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After a grant, favour the port that was not granted
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = grant_o[0];
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one EX-stage ALU between two requesters and owns the {Z,V,N} flags; honours ALU_SHARE_FIXED_PRIO_EN
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [OP_W-1:0]   req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_data_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] alu_in1_o,
    output logic [DATA_W-1:0] alu_in2_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic              alu_ovfl_i,
    input  logic              alu_neg_i,
    input  logic              alu_fwr_i,
    output logic [2:0]        flags_o
);

    state_e            state_q;
    logic [OP_W-1:0]   hold_op_q;
    logic [DATA_W-1:0] hold_a_q;
    logic [DATA_W-1:0] hold_b_q;
    logic              hold_id_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [2:0]        flags_q;
    logic [2:0]        flags_d;

    logic [1:0] grant;
    logic       in_idle;
    logic       hs;
    logic       sets_vn;

    assign in_idle = (state_q == ST_IDLE);

    arb_rr2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   ({req1_valid_i, req0_valid_i}),
        .adv_i   (hs),
        .grant_o (grant)
    );

    // Ready only for the granted port and only while idle, so RESP/EXEC accept nothing
    assign req0_ready_o = in_idle & grant[0];
    assign req1_ready_o = in_idle & grant[1];
    assign hs           = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);

    assign alu_in1_o   = hold_a_q;
    assign alu_in2_o   = hold_b_q;
    assign alu_op_o    = hold_op_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = hold_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign flags_o     = flags_q;

    // Only ADD/SUB produce meaningful overflow/negative; other ops keep V and N
    assign sets_vn = (hold_op_q == OP_W'(OP_ADD)) || (hold_op_q == OP_W'(OP_SUB));

    // Flag update happens in EXEC for port 0 flag-writing ops; port 1 never touches flags
    always_comb begin
        flags_d = flags_q;
        if ((state_q == ST_EXEC) && alu_fwr_i && !hold_id_q) begin
            flags_d[FLAG_Z] = (alu_out_i == '0);
            if (sets_vn) begin
                flags_d[FLAG_V] = alu_ovfl_i;
                flags_d[FLAG_N] = alu_neg_i;
            end
        end
    end

    // Sequencer: IDLE latches the granted request, EXEC captures the ALU result, RESP holds it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            hold_op_q   <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_id_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            flags_q     <= 3'b000;
        end else begin
            flags_q <= flags_d;
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        hold_id_q <= grant[1];
                        hold_op_q <= grant[1] ? req1_op_i : req0_op_i;
                        hold_a_q  <= grant[1] ? req1_a_i  : req0_a_i;
                        hold_b_q  <= grant[1] ? req1_b_i  : req0_b_i;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= alu_out_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [15:0] rsp_data;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_op;
    logic        alu_ovfl, alu_neg, alu_fwr;
    logic [2:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    alu_share_ctrl #(.DATA_W(16), .OP_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .rsp_ready_i  (rsp_ready),
        .alu_in1_o    (alu_in1),
        .alu_in2_o    (alu_in2),
        .alu_op_o     (alu_op),
        .alu_out_i    (alu_out),
        .alu_ovfl_i   (alu_ovfl),
        .alu_neg_i    (alu_neg),
        .alu_fwr_i    (alu_fwr),
        .flags_o      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational ALU the controller feeds
    always_comb begin
        alu_out  = 16'h0000;
        alu_ovfl = 1'b0;
        alu_fwr  = 1'b0;
        case (alu_op)
            4'h0: begin
                alu_out  = alu_in1 + alu_in2;
                alu_ovfl = (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]);
                alu_fwr  = 1'b1;
            end
            4'h1: begin
                alu_out  = alu_in1 - alu_in2;
                alu_ovfl = (alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15]);
                alu_fwr  = 1'b1;
            end
            4'h3: alu_out = alu_in1 | alu_in2;
            4'h4: begin
                alu_out = alu_in1 ^ alu_in2;
                alu_fwr = 1'b1;
            end
            default: alu_out = 16'h0000;
        endcase
    end
    assign alu_neg = alu_out[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_port;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 4'h0; req0_a = 16'h0; req0_b = 16'h0;
        req1_valid = 1'b0; req1_op = 4'h0; req1_a = 16'h0; req1_b = 16'h0;

        // Reset held two cycles
        tick(); tick();
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_ready0", 32'(req0_ready), 32'h0);
        check("rst_ready1", 32'(req1_ready), 32'h0);
        check("rst_alu_in1", 32'(alu_in1), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_noreq_ready0", 32'(req0_ready), 32'h0);

        // Port 0 ADD 7FFF+0001, latency N+2
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'h7FFF; req0_b = 16'h0001;
        #1;
        check("add_ready0", 32'(req0_ready), 32'h1);
        check("add_ready1", 32'(req1_ready), 32'h0);
        tick();
        req0_valid = 1'b0;
        check("add_exec_valid", 32'(rsp_valid), 32'h0);
        check("add_exec_in1", 32'(alu_in1), 32'h7FFF);
        check("add_exec_in2", 32'(alu_in2), 32'h0001);
        tick();
        check("add_rsp_valid", 32'(rsp_valid), 32'h1);
        check("add_rsp_data", 32'(rsp_data), 32'h8000);
        check("add_rsp_id", 32'(rsp_id), 32'h0);
        check("add_flags", 32'(flags), 32'h3);
        tick();
        check("add_done_valid", 32'(rsp_valid), 32'h0);

        // Port 1 alone: SUB 5-5 gives zero but must not write flags
        req1_valid = 1'b1; req1_op = 4'h1; req1_a = 16'h0005; req1_b = 16'h0005;
        #1;
        check("sub1_ready1", 32'(req1_ready), 32'h1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("sub1_rsp_data", 32'(rsp_data), 32'h0);
        check("sub1_rsp_id", 32'(rsp_id), 32'h1);
        check("sub1_flags", 32'(flags), 32'h3);
        tick();

        // Both valid continuously: port 0 OR (no flag write), port 1 SUB
        req0_valid = 1'b1; req0_op = 4'h3; req0_a = 16'h1200; req0_b = 16'h0034;
        req1_valid = 1'b1; req1_op = 4'h1; req1_a = 16'h0005; req1_b = 16'h0005;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
            exp_port = 0;
`else
            exp_port = k % 2;
`endif
            check("alt_ready0", 32'(req0_ready), 32'(exp_port == 0));
            check("alt_ready1", 32'(req1_ready), 32'(exp_port == 1));
            tick();
            check("alt_exec_valid", 32'(rsp_valid), 32'h0);
            tick();
            check("alt_rsp_id", 32'(rsp_id), 32'(exp_port));
            check("alt_rsp_data", 32'(rsp_data), (exp_port == 0) ? 32'h1234 : 32'h0);
            check("alt_resp_ready0", 32'(req0_ready), 32'h0);
            check("alt_flags", 32'(flags), 32'h3);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // XOR to zero: Z set, V/N retained
        req0_valid = 1'b1; req0_op = 4'h4; req0_a = 16'hAAAA; req0_b = 16'hAAAA;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("xor_rsp_data", 32'(rsp_data), 32'h0);
        check("xor_flags", 32'(flags), 32'h7);
        tick();

        // Consumer stalls ten cycles while both requesters wait
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'hFFFF; req0_b = 16'h0001;
        #1;
        tick();
        req1_valid = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", 32'(rsp_valid), 32'h1);
            check("stall_data", 32'(rsp_data), 32'h0);
            check("stall_id", 32'(rsp_id), 32'h0);
            check("stall_ready0", 32'(req0_ready), 32'h0);
            check("stall_ready1", 32'(req1_ready), 32'h0);
            tick();
        end
        check("stall_flags", 32'(flags), 32'h4);
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("stall_accept_valid", 32'(rsp_valid), 32'h0);
        check("stall_idle_ready0", 32'(req0_ready), 32'h1);
        check("drop_ready1", 32'(req1_ready), 32'h0);
        req0_valid = 1'b0;
        tick();
        check("drop_no_effect_a", 32'(rsp_valid), 32'h0);
        tick();
        check("drop_no_effect_b", 32'(rsp_valid), 32'h0);

        // Reset during EXEC discards the result and clears flags
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'h7FFF; req0_b = 16'h0001;
        #1;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("rstexec_valid", 32'(rsp_valid), 32'h0);
        check("rstexec_flags", 32'(flags), 32'h0);
        check("rstexec_data", 32'(rsp_data), 32'h0);
        check("rstexec_in1", 32'(alu_in1), 32'h0);
        rst = 1'b0;
        tick();
        check("rstexec_idle_valid", 32'(rsp_valid), 32'h0);
        tick();
        check("rstexec_idle_valid2", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
